sti_load_sched: RTL and testbench

Round-robin load scheduler sitting in front of the STI_DAC serializer core. It accepts parallel words from two independent requesters, grants one at a time, and issues a single-cycle `load` with the word's fields. It then tracks the serial transfer through `so_valid`, checking the bit count and a watchdog. At end of session it issues `pi_end` and waits for `pixel_finish`.

---
 rtl/sti_load_sched.sv | 153 +++++++++++++++
 tb/tb_sti_load_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sti_load_sched.sv
// Round-robin load scheduler in front of the STI_DAC serializer: grants one of two
// requesters, strobes the word into the core, then supervises the serial transfer.
module sti_load_sched #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rq0_valid,
    input  logic        rq1_valid,
    output logic        rq0_ready,
    output logic        rq1_ready,
    input  logic [20:0] rq0_word,
    input  logic [20:0] rq1_word,
    input  logic        end_req,
    output logic        load,
    output logic [15:0] pi_data,
    output logic [1:0]  pi_length,
    output logic        pi_fill,
    output logic        pi_msb,
    output logic        pi_low,
    output logic        pi_end,
    input  logic        so_valid,
    input  logic        pixel_finish,
    output logic        grant_id,
    output logic        busy,
    output logic        len_err,
    output logic        timeout_err,
    output logic        done,
    output logic [15:0] words_sent
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, ACCEPT, LOAD, WAIT_START, WAIT_DONE, END, FIN, DONE
    } state_t;

    state_t      state_q;
    logic        rq0_rdy_q, rq1_rdy_q, load_q, pi_end_q;
    logic [20:0] pi_word_q;
    logic        sel_q, grant_q, last_q;
    logic [5:0]  exp_q, bits_q;
    logic [WDW-1:0] wd_q;
    logic        len_err_q, to_err_q, done_q;
    logic [15:0] words_q;
    logic        pick1;

    // rq1 wins when it is the only one pending, or on contention when rq0 went last
    assign pick1 = rq1_valid & (~rq0_valid | ~last_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rq0_rdy_q <= 1'b0;
            rq1_rdy_q <= 1'b0;
            load_q    <= 1'b0;
            pi_end_q  <= 1'b0;
            pi_word_q <= '0;
            sel_q     <= 1'b0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            exp_q     <= '0;
            bits_q    <= '0;
            wd_q      <= '0;
            len_err_q <= 1'b0;
            to_err_q  <= 1'b0;
            done_q    <= 1'b0;
            words_q   <= '0;
        end else begin
            rq0_rdy_q <= 1'b0;
            rq1_rdy_q <= 1'b0;
            load_q    <= 1'b0;
            pi_end_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rq0_valid | rq1_valid) begin
                        sel_q     <= pick1;
                        rq0_rdy_q <= ~pick1;
                        rq1_rdy_q <= pick1;
                        state_q   <= ACCEPT;
                    end else if (end_req) begin
                        pi_end_q <= 1'b1;
                        state_q  <= END;
                    end
                end
                ACCEPT: begin
                    // ready is up this cycle; a dropped valid withdraws the request
                    if (sel_q ? rq1_valid : rq0_valid) begin
                        pi_word_q <= sel_q ? rq1_word : rq0_word;
                        grant_q   <= sel_q;
                        last_q    <= sel_q;
                        load_q    <= 1'b1;
                        state_q   <= LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOAD: begin
                    exp_q   <= {3'({1'b0, pi_word_q[17:16]}) + 3'd1, 3'b000};
                    wd_q    <= '0;
                    state_q <= WAIT_START;
                end
                WAIT_START: begin
                    if (so_valid) begin
                        bits_q  <= 6'd1;
                        wd_q    <= '0;
                        state_q <= WAIT_DONE;
                    end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                        to_err_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    // every cycle here either counts a bit (re-arming the watchdog) or ends
                    if (so_valid) begin
                        bits_q <= (bits_q != 6'd63) ? bits_q + 6'd1 : bits_q;
                        wd_q   <= '0;
                    end else begin
                        len_err_q <= len_err_q | (bits_q != exp_q);
                        words_q   <= words_q + 16'd1;
                        state_q   <= IDLE;
                    end
                end
                END: state_q <= FIN;
                FIN: begin
                    if (pixel_finish) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rq0_ready   = rq0_rdy_q;
    assign rq1_ready   = rq1_rdy_q;
    assign load        = load_q;
    assign pi_end      = pi_end_q;
    assign pi_data     = pi_word_q[15:0];
    assign pi_length   = pi_word_q[17:16];
    assign pi_low      = pi_word_q[18];
    assign pi_msb      = pi_word_q[19];
    assign pi_fill     = pi_word_q[20];
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign len_err     = len_err_q;
    assign timeout_err = to_err_q;
    assign done        = done_q;
    assign words_sent  = words_q;
endmodule

// File: tb/tb_sti_load_sched.sv
// Randomized bench for sti_load_sched: the bench plays both requesters and the STI core,
// and predicts grants, counters and sticky flags from a small behavioural model.
module tb_sti_load_sched;
    logic        clk = 1'b0, reset = 1'b1;
    logic        rq0_valid = 1'b0, rq1_valid = 1'b0;
    logic        rq0_ready, rq1_ready;
    logic [20:0] rq0_word = '0, rq1_word = '0;
    logic        end_req = 1'b0, so_valid = 1'b0, pixel_finish = 1'b0;
    logic        load, pi_fill, pi_msb, pi_low, pi_end;
    logic [15:0] pi_data, words_sent;
    logic [1:0]  pi_length;
    logic        grant_id, busy, len_err, timeout_err, done;

    int total = 0, bad = 0;
    int m_words;
    bit m_len_err, m_to_err, m_last;

    sti_load_sched #(.TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .rq0_valid(rq0_valid), .rq1_valid(rq1_valid),
        .rq0_ready(rq0_ready), .rq1_ready(rq1_ready),
        .rq0_word(rq0_word), .rq1_word(rq1_word),
        .end_req(end_req), .load(load),
        .pi_data(pi_data), .pi_length(pi_length),
        .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .so_valid(so_valid), .pixel_finish(pixel_finish),
        .grant_id(grant_id), .busy(busy), .len_err(len_err),
        .timeout_err(timeout_err), .done(done), .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int exp_grant(bit v0, bit v1);
        if (v0 && v1) return m_last ? 0 : 1;
        return v1 ? 1 : 0;
    endfunction

    function automatic logic [20:0] rand_word();
        return 21'($urandom);
    endfunction

    function automatic void model_reset();
        m_words = 0; m_len_err = 0; m_to_err = 0; m_last = 1;
    endfunction

    // Plays one full transfer; returns what it observed, judging is left to the caller.
    task automatic xfer(input int nbits, input bit keep, output int rid, output int lat,
                        output bit ld, output logic [20:0] piw, output logic gid,
                        output logic [20:0] w);
        int nb;
        rid = -1; lat = 0; ld = 0; piw = '0; gid = 0; w = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rq0_ready || rq1_ready) begin
                lat = i;
                rid = (rq0_ready && rq1_ready) ? 2 : (rq1_ready ? 1 : 0);
                break;
            end
        end
        if (rid < 0) return;
        w = (rid == 1) ? rq1_word : rq0_word;
        @(negedge clk);
        ld  = load;
        piw = {pi_fill, pi_msb, pi_low, pi_length, pi_data};
        gid = grant_id;
        if (keep) begin
            if (rid == 1) rq1_word = rand_word(); else rq0_word = rand_word();
        end else begin
            if (rid == 1) rq1_valid = 0; else rq0_valid = 0;
        end
        nb = (nbits < 0) ? 8 * (int'(w[17:16]) + 1) : nbits;
        @(negedge clk);
        so_valid = 1;
        repeat (nb) @(negedge clk);
        so_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1; rq0_valid = 0; rq1_valid = 0; end_req = 0; so_valid = 0; pixel_finish = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({load, pi_end, rq0_ready, rq1_ready, grant_id, busy, len_err, timeout_err, done} !== 9'b0) begin
            bad++; $display("FAIL reset_ctrl: got=%b exp=0",
                {load, pi_end, rq0_ready, rq1_ready, grant_id, busy, len_err, timeout_err, done});
        end
        total++;
        if ({pi_fill, pi_msb, pi_low, pi_length, pi_data} !== 21'b0) begin
            bad++; $display("FAIL reset_pi: got=%h exp=0", {pi_fill, pi_msb, pi_low, pi_length, pi_data});
        end
        total++;
        if (words_sent !== 16'd0) begin bad++; $display("FAIL reset_words: got=%0d exp=0", words_sent); end
        reset = 0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_single();
        int rid, lat; bit ld; logic [20:0] piw, w; logic gid;
        rq0_word = {1'b0, 1'b0, 1'b0, 2'd1, 16'hAB12};
        rq0_valid = 1;
        xfer(-1, 0, rid, lat, ld, piw, gid, w);
        m_words++; m_last = 0;
        total++; if (rid !== 0) begin bad++; $display("FAIL single_rid: got=%0d exp=0", rid); end
        total++; if (lat !== 1) begin bad++; $display("FAIL single_ready_latency: got=%0d exp=1", lat); end
        total++; if (ld !== 1'b1) begin bad++; $display("FAIL single_load: got=%b exp=1", ld); end
        total++; if (piw[15:0] !== 16'hAB12) begin bad++; $display("FAIL single_pi_data: got=%h exp=ab12", piw[15:0]); end
        total++; if (piw[17:16] !== 2'd1) begin bad++; $display("FAIL single_pi_length: got=%0d exp=1", piw[17:16]); end
        total++; if (gid !== 1'b0) begin bad++; $display("FAIL single_grant: got=%b exp=0", gid); end
        total++; if (words_sent !== 16'(m_words)) begin bad++; $display("FAIL single_words: got=%0d exp=%0d", words_sent, m_words); end
        total++; if (len_err !== 1'b0) begin bad++; $display("FAIL single_len_err: got=%b exp=0", len_err); end
    endtask

    task automatic test_contention();
        int rid, lat, eg; bit ld; logic [20:0] piw, w, ew; logic gid;
        rq0_word = rand_word(); rq1_word = rand_word();
        rq0_valid = 1; rq1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            eg = exp_grant(1, 1);
            ew = (eg == 1) ? rq1_word : rq0_word;
            xfer(-1, 1, rid, lat, ld, piw, gid, w);
            m_last = eg[0]; m_words++;
            total++; if (rid !== eg) begin bad++; $display("FAIL cont_rid[%0d]: got=%0d exp=%0d", k, rid, eg); end
            total++; if (gid !== eg[0]) begin bad++; $display("FAIL cont_grant[%0d]: got=%b exp=%0d", k, gid, eg); end
            total++; if (ld !== 1'b1 || piw !== ew) begin
                bad++; $display("FAIL cont_pi[%0d]: got load=%b word=%h exp load=1 word=%h", k, ld, piw, ew);
            end
            total++; if (words_sent !== 16'(m_words)) begin bad++; $display("FAIL cont_words[%0d]: got=%0d exp=%0d", k, words_sent, m_words); end
        end
        rq0_valid = 0; rq1_valid = 0;
        @(negedge clk);
        total++; if (len_err !== m_len_err) begin bad++; $display("FAIL cont_len_err: got=%b exp=%b", len_err, m_len_err); end
    endtask

    task automatic test_len_err();
        int rid, lat, eg; bit ld; logic [20:0] piw, w, tw; logic gid;
        tw = rand_word(); tw[17:16] = 2'd2;
        rq1_word = tw; rq1_valid = 1;
        eg = exp_grant(0, 1);
        xfer(23, 0, rid, lat, ld, piw, gid, w);
        m_last = eg[0]; m_words++;
        if (23 != 8 * (int'(tw[17:16]) + 1)) m_len_err = 1;
        total++; if (rid !== eg) begin bad++; $display("FAIL lenerr_rid: got=%0d exp=%0d", rid, eg); end
        total++; if (len_err !== m_len_err) begin bad++; $display("FAIL lenerr_flag: got=%b exp=%b", len_err, m_len_err); end
        total++; if (words_sent !== 16'(m_words)) begin bad++; $display("FAIL lenerr_words: got=%0d exp=%0d", words_sent, m_words); end
        tw = rand_word(); tw[17:16] = 2'd3;
        rq0_word = tw; rq0_valid = 1;
        eg = exp_grant(1, 0);
        xfer(-1, 0, rid, lat, ld, piw, gid, w);
        m_last = eg[0]; m_words++;
        total++; if (piw !== tw) begin bad++; $display("FAIL lenerr_pi32: got=%h exp=%h", piw, tw); end
        total++; if (len_err !== m_len_err) begin bad++; $display("FAIL lenerr_sticky: got=%b exp=%b", len_err, m_len_err); end
        total++; if (words_sent !== 16'(m_words)) begin bad++; $display("FAIL lenerr_words32: got=%0d exp=%0d", words_sent, m_words); end
    endtask

    task automatic test_watchdog();
        bit got, ld; int k;
        rq0_word = rand_word(); rq0_valid = 1; got = 0; k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rq0_ready) begin got = 1; break; end
        end
        @(negedge clk);
        rq0_valid = 0; ld = load;
        if (got) m_last = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (timeout_err) begin k = i; break; end
        end
        m_to_err = 1;
        total++; if (!got || ld !== 1'b1) begin bad++; $display("FAIL wd_start: got ready=%b load=%b exp 1 1", got, ld); end
        total++; if (k < 64 || k > 66) begin bad++; $display("FAIL wd_delay: got=%0d exp=64..66", k); end
        total++; if (timeout_err !== m_to_err || busy !== 1'b0) begin
            bad++; $display("FAIL wd_state: got to=%b busy=%b exp to=1 busy=0", timeout_err, busy);
        end
        total++; if (words_sent !== 16'(m_words)) begin bad++; $display("FAIL wd_words: got=%0d exp=%0d", words_sent, m_words); end
    endtask

    task automatic test_reset_mid();
        int rid, lat, eg; bit ld; logic [20:0] piw, w, tw; logic gid;
        rq0_word = rand_word(); rq0_valid = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rq0_ready) break;
        end
        @(negedge clk);
        rq0_valid = 0;
        @(negedge clk);
        so_valid = 1;
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got=%b exp=1", busy); end
        reset = 1; so_valid = 0;
        @(negedge clk);
        total++;
        if ({load, pi_end, rq0_ready, rq1_ready, grant_id, busy, len_err, timeout_err, done} !== 9'b0) begin
            bad++; $display("FAIL mid_reset_ctrl: got=%b exp=0",
                {load, pi_end, rq0_ready, rq1_ready, grant_id, busy, len_err, timeout_err, done});
        end
        total++;
        if ({pi_fill, pi_msb, pi_low, pi_length, pi_data} !== 21'b0 || words_sent !== 16'd0) begin
            bad++; $display("FAIL mid_reset_data: got pi=%h words=%0d exp 0 0",
                {pi_fill, pi_msb, pi_low, pi_length, pi_data}, words_sent);
        end
        reset = 0; model_reset();
        @(negedge clk);
        tw = rand_word(); rq1_word = tw; rq1_valid = 1;
        eg = exp_grant(0, 1);
        xfer(-1, 0, rid, lat, ld, piw, gid, w);
        m_last = eg[0]; m_words++;
        total++; if (rid !== eg || gid !== eg[0]) begin bad++; $display("FAIL mid_after_grant: got rid=%0d gid=%b exp=%0d", rid, gid, eg); end
        total++; if (ld !== 1'b1 || piw !== tw) begin bad++; $display("FAIL mid_after_pi: got load=%b word=%h exp word=%h", ld, piw, tw); end
        total++; if (words_sent !== 16'(m_words) || len_err !== m_len_err || timeout_err !== m_to_err) begin
            bad++; $display("FAIL mid_after_flags: got words=%0d len=%b to=%b exp words=%0d len=%b to=%b",
                words_sent, len_err, timeout_err, m_words, m_len_err, m_to_err);
        end
    endtask

    task automatic test_end();
        int rid, lat, eg, pe, rdy; bit ld; logic [20:0] piw, w; logic gid;
        rq1_word = rand_word(); rq1_valid = 1; end_req = 1;
        eg = exp_grant(0, 1);
        xfer(-1, 0, rid, lat, ld, piw, gid, w);
        m_last = eg[0]; m_words++;
        total++; if (rid !== 1 || lat !== 1) begin bad++; $display("FAIL end_word_first: got rid=%0d lat=%0d exp 1 1", rid, lat); end
        total++; if (words_sent !== 16'(m_words)) begin bad++; $display("FAIL end_words: got=%0d exp=%0d", words_sent, m_words); end
        pe = 0;
        repeat (8) begin
            @(negedge clk);
            if (pi_end) pe++;
        end
        total++; if (pe !== 1) begin bad++; $display("FAIL end_pi_end_pulses: got=%0d exp=1", pe); end
        total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL end_fin_wait: got done=%b busy=%b exp 0 1", done, busy); end
        repeat (2) @(negedge clk);
        pixel_finish = 1;
        @(negedge clk);
        pixel_finish = 0; end_req = 0;
        @(negedge clk);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL end_done: got done=%b busy=%b exp 1 0", done, busy); end
        rq0_valid = 1; rdy = 0;
        repeat (10) begin
            @(negedge clk);
            if (rq0_ready || rq1_ready || load) rdy++;
        end
        rq0_valid = 0;
        total++; if (rdy !== 0) begin bad++; $display("FAIL end_no_ready: got=%0d exp=0", rdy); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_len_err();
        test_watchdog();
        test_reset_mid();
        test_end();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
